// File: rtl/req_encoder_4_2_if.sv
// Request/handshake bundle for the 4:2 request encoder: request inputs,
// downstream accept, and the registered index, valid and observability outputs.
interface req_encoder_4_2_if;
    logic [3:0] in;
    logic       ready;
    logic [1:0] out;
    logic       valid;
    logic [3:0] pending;
    logic       lost;

    modport master (
        output in,
        output ready,
        input  out,
        input  valid,
        input  pending,
        input  lost
    );

    modport slave (
        input  in,
        input  ready,
        output out,
        output valid,
        output pending,
        output lost
    );
endinterface

// File: rtl/req_encoder_4_2.sv
// Registered 4:2 fixed-priority request encoder. Requests are merged into a
// pending register and emitted one index at a time, highest bit first.
module req_encoder_4_2 (
    input  logic               clk,
    input  logic               rst_n,
    req_encoder_4_2_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_p0;
    logic [1:0] out_p0;
    logic [3:0] pending_p0;
    logic       lost_p0;

    logic [3:0] cand;
    logic [3:0] g;
    logic [3:0] g_eff;
    logic       load;

    function automatic logic [3:0] top_onehot(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v[3])      r = 4'b1000;
        else if (v[2]) r = 4'b0100;
        else if (v[1]) r = 4'b0010;
        else if (v[0]) r = 4'b0001;
        return r;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r;
        r = 2'b00;
        if (v[3])      r = 2'b11;
        else if (v[2]) r = 2'b10;
        else if (v[1]) r = 2'b01;
        return r;
    endfunction

    always_comb begin
        cand  = pending_p0 | bus.in;
        load  = (state_p0 == IDLE) || bus.ready;
        g     = top_onehot(cand);
        g_eff = load ? g : 4'b0000;
    end

    // Single register stage: handshake state, held index, pending set and lost pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0   <= IDLE;
            out_p0     <= 2'b00;
            pending_p0 <= 4'b0000;
            lost_p0    <= 1'b0;
        end else begin
            lost_p0 <= |(bus.in & pending_p0 & ~g_eff);
            if (load) begin
                state_p0 <= (|cand) ? HOLD : IDLE;
                if (|cand)
                    out_p0 <= enc(cand);
                // A fresh request on the bit granted out of pending is a new event and stays pending.
                pending_p0 <= (cand & ~g) | (bus.in & pending_p0 & g);
            end else begin
                pending_p0 <= pending_p0 | bus.in;
            end
        end
    end

    assign bus.out     = out_p0;
    assign bus.valid   = (state_p0 == HOLD);
    assign bus.pending = pending_p0;
    assign bus.lost    = lost_p0;

endmodule

// File: tb/tb_req_encoder_4_2.sv
// Self-checking bench for req_encoder_4_2: directed scenarios followed by
// randomized traffic, all compared against a bit-level behavioural model.
module tb_req_encoder_4_2;

    logic clk;
    logic rst_n;
    req_encoder_4_2_if bus ();

    req_encoder_4_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [3:0] m_pend;
    logic [1:0] m_out;
    logic       m_valid;
    logic       m_lost;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 4'b0000;
        m_out   = 2'b00;
        m_valid = 1'b0;
        m_lost  = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic [3:0] i, input logic r);
        bit         accept;
        int         win;
        logic [3:0] np;
        bit         lo;
        accept = !m_valid || r;
        win = -1;
        for (int k = 3; k >= 0; k--)
            if (win < 0 && (m_pend[k] || i[k])) win = k;
        lo = 1'b0;
        for (int j = 0; j < 4; j++)
            if (i[j] && m_pend[j] && !(accept && j == win)) lo = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (accept && j == win) np[j] = m_pend[j] && i[j];
            else                    np[j] = m_pend[j] || i[j];
        end
        if (accept) begin
            m_valid = (win >= 0);
            if (win >= 0) m_out = 2'(win);
        end
        m_pend = np;
        m_lost = lo;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   {3'b000, bus.valid}, {3'b000, m_valid});
        chk({tag, ".out"},     {2'b00, bus.out},    {2'b00, m_out});
        chk({tag, ".pending"}, bus.pending,         m_pend);
        chk({tag, ".lost"},    {3'b000, bus.lost},  {3'b000, m_lost});
    endtask

    // Called at a falling edge: drive, clock, then sample at the next falling edge.
    task automatic cycle(input string tag, input logic [3:0] i, input logic r);
        bus.in    = i;
        bus.ready = r;
        model_edge(i, r);
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        logic [3:0] rin;
        logic       rrdy;

        rst_n     = 1'b0;
        bus.in    = 4'b0000;
        bus.ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;

        // Reset asserted mid-cycle with traffic in flight
        cycle("rst_pre", 4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rst_async");
        @(negedge clk);
        bus.in = 4'b0000;
        rst_n  = 1'b1;
        cycle("rst_rel0", 4'b0000, 1'b1);
        cycle("rst_rel1", 4'b0000, 1'b1);
        chk("rst_valid_low", {3'b000, bus.valid}, 4'h0);

        // Single request
        cycle("single0", 4'b0100, 1'b1);
        chk("single_out", {2'b00, bus.out}, 4'h2);
        chk("single_valid", {3'b000, bus.valid}, 4'h1);
        cycle("single1", 4'b0000, 1'b1);
        chk("single_idle", {3'b000, bus.valid}, 4'h0);

        // Multi-hot ordering
        cycle("multi0", 4'b1011, 1'b1);
        chk("multi_out0", {2'b00, bus.out}, 4'h3);
        cycle("multi1", 4'b0000, 1'b1);
        chk("multi_out1", {2'b00, bus.out}, 4'h1);
        cycle("multi2", 4'b0000, 1'b1);
        chk("multi_out2", {2'b00, bus.out}, 4'h0);
        cycle("multi3", 4'b0000, 1'b1);
        chk("multi_idle", {3'b000, bus.valid}, 4'h0);

        // Backpressure, then merge while stalled
        cycle("bp0", 4'b0011, 1'b0);
        for (int n = 0; n < 4; n++) cycle("bp_hold", 4'b0000, 1'b0);
        chk("bp_out", {2'b00, bus.out}, 4'h1);
        chk("bp_pending", bus.pending, 4'b0001);
        cycle("lost0", 4'b0001, 1'b0);
        chk("lost_pulse", {3'b000, bus.lost}, 4'h1);
        chk("lost_pending", bus.pending, 4'b0001);
        cycle("lost1", 4'b0000, 1'b0);
        chk("lost_clear", {3'b000, bus.lost}, 4'h0);
        cycle("bp_acc0", 4'b0000, 1'b1);
        chk("bp_out_next", {2'b00, bus.out}, 4'h0);
        cycle("bp_acc1", 4'b0000, 1'b1);
        chk("bp_idle", {3'b000, bus.valid}, 4'h0);

        // Grant from pending coinciding with a re-request of the same bit
        cycle("regrant0", 4'b1010, 1'b1);
        cycle("regrant1", 4'b0010, 1'b1);
        chk("regrant_out", {2'b00, bus.out}, 4'h1);
        chk("regrant_pending", bus.pending, 4'b0010);
        chk("regrant_lost", {3'b000, bus.lost}, 4'h0);
        cycle("regrant2", 4'b0000, 1'b1);
        chk("regrant_out2", {2'b00, bus.out}, 4'h1);
        chk("regrant_valid2", {3'b000, bus.valid}, 4'h1);
        cycle("regrant3", 4'b0000, 1'b1);

        // Continuous request starves lower bits
        for (int n = 0; n < 3; n++) cycle("starve", 4'b1001, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rin  = 4'($urandom);
            if ($urandom_range(0, 2) != 0) rin = 4'b0000;
            rrdy = ($urandom_range(0, 3) != 0);
            cycle("rand", rin, rrdy);
        end
        for (int n = 0; n < 6; n++) cycle("drain", 4'b0000, 1'b1);
        chk("drain_idle", {3'b000, bus.valid}, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
